reg_file_sb: RTL and testbench

Parametrised register file for the RISC-V core: a generalised successor to the single-issue 32x32 register file. It provides NRD combinational read ports with write-through bypass, a hardwired-zero register 0, and full asynchronous clear. A per-register pending-writer scoreboard lets the pipeline detect RAW hazards and stall issue. It sits between decode (reads, issue) and writeback (writes).

---
 rtl/rf_pkg.sv | 12 +
 rtl/reg_pend_counter.sv | 26 ++
 rtl/reg_file_sb.sv | 86 ++++++++
 tb/tb_reg_file_sb.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults and address-validity helper for the register file
package rf_pkg;
    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int NRD_DEF  = 2;
    localparam int PW_DEF   = 2;

    // Register 0 is hardwired to zero and addresses past NREG do not exist.
    function automatic logic rf_addr_ok(input logic [31:0] addr, input int unsigned nreg = NREG_DEF);
        return (addr != 32'd0) && (addr < nreg);
    endfunction
endpackage

// File: rtl/reg_pend_counter.sv
// reg_pend_counter: saturating pending-writer counter for one register
module reg_pend_counter #(
    parameter int PW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    output logic [PW-1:0] count,
    output logic          busy,
    output logic          full,
    output logic          underflow
);
    assign busy      = |count;
    assign full      = &count;
    assign underflow = dec && !inc && !busy;

    // Simultaneous inc and dec cancel, including at zero.
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            count <= '0;
        else if (inc && !dec && !full)
            count <= count + PW'(1);
        else if (dec && !inc && busy)
            count <= count - PW'(1);
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-port register file with write-through bypass, x0 = 0,
// and a per-register pending-writer scoreboard for RAW hazard detection.
module reg_file_sb
    import rf_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int AW   = $clog2(NREG),
    parameter int NRD  = NRD_DEF,
    parameter int PW   = PW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic                iss_stall,
    output logic                wb_err
);
    // Arrays span the full address space so any address indexes safely;
    // slots 0 and >= NREG are constant zero.
    localparam int NSLOT = 2 ** AW;

    logic [XLEN-1:0]  regs [NSLOT];
    logic [PW-1:0]    cnt  [NSLOT];
    logic [NSLOT-1:0] busy_v;
    logic [NSLOT-1:0] full_v;
    logic [NSLOT-1:0] uf_v;
    logic             wr_ok;
    logic             iss_ok;
    logic             iss_acc;

    assign wr_ok     = wr_en && rf_addr_ok(32'(wr_addr), NREG);
    assign iss_ok    = iss_en && rf_addr_ok(32'(iss_addr), NREG);
    assign iss_stall = rst && iss_ok && full_v[iss_addr] && !(wr_en && wr_addr == iss_addr);
    assign iss_acc   = iss_ok && !iss_stall;

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            for (int k = 0; k < NSLOT; k++) regs[k] <= '0;
        else if (wr_ok)
            regs[wr_addr] <= wr_data;

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            wb_err <= 1'b0;
        else if (|uf_v)
            wb_err <= 1'b1;

    for (genvar r = 0; r < NSLOT; r++) begin : g_slot
        if (r == 0 || r >= NREG) begin : g_none
            assign cnt[r]    = '0;
            assign busy_v[r] = 1'b0;
            assign full_v[r] = 1'b0;
            assign uf_v[r]   = 1'b0;
        end else begin : g_cnt
            reg_pend_counter #(.PW(PW)) u_cnt (
                .clk       (clk),
                .rst       (rst),
                .inc       (iss_acc && iss_addr == AW'(r)),
                .dec       (wr_en && wr_addr == AW'(r)),
                .count     (cnt[r]),
                .busy      (busy_v[r]),
                .full      (full_v[r]),
                .underflow (uf_v[r])
            );
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] ra;
        logic          ok;
        logic          hit;
        assign ra  = rd_addr[i*AW +: AW];
        assign ok  = rf_addr_ok(32'(ra), NREG);
        assign hit = wr_en && wr_addr == ra;
        assign rd_data[i*XLEN +: XLEN] = (rst && ok) ? (hit ? wr_data : regs[ra]) : '0;
        // A same-cycle writeback retires one pending writer before it is seen.
        assign rd_busy[i] = rst && ok && busy_v[ra] && !(hit && cnt[ra] == PW'(1));
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed and randomized checks of reg_file_sb against an array model
module tb_reg_file_sb;
    localparam int XLEN = 32;
    localparam int NREG = 24;
    localparam int NRD  = 2;
    localparam int PW   = 2;
    localparam int AW   = 5;
    localparam int CMAX = 2 ** PW - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                iss_stall;
    logic                wb_err;

    int vectors = 0;
    int miscompares = 0;

    logic [XLEN-1:0] mem [NREG];
    int              cnt [NREG];
    bit              err;

    reg_file_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD), .PW(PW)) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .iss_stall (iss_stall),
        .wb_err    (wb_err)
    );

    always #5 clk = ~clk;

    function automatic bit ok(int a);
        return a > 0 && a < NREG;
    endfunction

    function automatic logic [XLEN-1:0] exp_rd(int a);
        if (!ok(a)) return '0;
        if (wr_en && int'(wr_addr) == a) return wr_data;
        return mem[a];
    endfunction

    function automatic bit exp_busy(int a);
        int c;
        if (!ok(a)) return 1'b0;
        c = cnt[a];
        if (wr_en && int'(wr_addr) == a && c > 0) c--;
        return c != 0;
    endfunction

    function automatic bit exp_stall();
        int s;
        s = int'(iss_addr);
        return iss_en && ok(s) && cnt[s] == CMAX && !(wr_en && int'(wr_addr) == s);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NREG; k++) begin
            mem[k] = '0;
            cnt[k] = 0;
        end
        err = 1'b0;
    endtask

    task automatic idle();
        wr_en = 0; wr_addr = '0; wr_data = '0; iss_en = 0; iss_addr = '0;
    endtask

    task automatic set_rd(int a0, int a1);
        rd_addr = {AW'(a1), AW'(a0)};
    endtask

    // Advance one clock, applying the architectural effect of the current inputs to the model.
    task automatic cycle();
        int w, s;
        bit wok, acc;
        w = int'(wr_addr);
        s = int'(iss_addr);
        wok = wr_en && ok(w);
        acc = iss_en && ok(s) && !exp_stall();
        if (wok) mem[w] = wr_data;
        if (!(acc && wok && s == w)) begin
            if (acc) cnt[s]++;
            if (wok) begin
                if (cnt[w] == 0) err = 1'b1;
                else cnt[w]--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        set_rd(0, 0);
        #3 rst = 1'b0;
        model_reset();
        for (int a = 0; a < 32; a++) begin
            set_rd(a, 31 - a);
            #1;
            vectors++;
            if ({rd_data, rd_busy, wb_err, iss_stall} !== '0) begin
                miscompares++;
                $display("FAIL reset_read a=%0d: got data=%h busy=%b err=%b stall=%b want all zero", a, rd_data, rd_busy, wb_err, iss_stall);
            end
        end
        wr_en = 1; wr_addr = 5; wr_data = 32'hCAFEF00D; iss_en = 1; iss_addr = 5;
        set_rd(5, 5);
        #1;
        vectors++;
        if (rd_data !== '0 || iss_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_bypass: got data=%h stall=%b want 0/0", rd_data, iss_stall);
        end
        idle();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_saturate();
        set_rd(7, 0);
        iss_en = 1; iss_addr = 7;
        for (int k = 0; k < CMAX; k++) begin
            #1;
            vectors++;
            if (iss_stall !== 1'b0) begin
                miscompares++;
                $display("FAIL sat_issue%0d: got stall=%b want 0", k, iss_stall);
            end
            cycle();
        end
        vectors++;
        if (rd_busy[0] !== 1'b1 || iss_stall !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_full: got busy=%b stall=%b want 1/1", rd_busy[0], iss_stall);
        end
        cycle();
        vectors++;
        if (iss_stall !== 1'b1 || cnt[7] != CMAX) begin
            miscompares++;
            $display("FAIL sat_hold: got stall=%b want 1", iss_stall);
        end
        wr_en = 1; wr_addr = 7; wr_data = 32'h0000_0077;
        #1;
        vectors++;
        if (iss_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_wb_unstall: got stall=%b want 0", iss_stall);
        end
        iss_en = 0;
        for (int k = 0; k < CMAX; k++) begin
            wr_data = $urandom;
            #1;
            vectors++;
            if (rd_busy[0] !== (k < CMAX - 1)) begin
                miscompares++;
                $display("FAIL sat_drain%0d: got busy=%b want %b", k, rd_busy[0], k < CMAX - 1);
            end
            cycle();
        end
        idle();
        #1;
        vectors++;
        if (rd_busy[0] !== 1'b0 || wb_err !== 1'b0 || rd_data[XLEN-1:0] !== mem[7]) begin
            miscompares++;
            $display("FAIL sat_done: got busy=%b err=%b data=%h want 0/0/%h", rd_busy[0], wb_err, rd_data[XLEN-1:0], mem[7]);
        end
    endtask

    task automatic test_same_cycle();
        set_rd(9, 9);
        iss_en = 1; iss_addr = 9;
        cycle();
        wr_en = 1; wr_addr = 9; wr_data = 32'h0909_0909;
        #1;
        vectors++;
        if (rd_busy !== 2'b00 || iss_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL same1_comb: got busy=%b stall=%b want 00/0", rd_busy, iss_stall);
        end
        cycle();
        idle();
        #1;
        vectors++;
        if (rd_busy !== 2'b11 || rd_data !== {2{32'h0909_0909}}) begin
            miscompares++;
            $display("FAIL same1_hold: got busy=%b data=%h want 11/09090909", rd_busy, rd_data);
        end
        wr_en = 1; wr_addr = 9; wr_data = 32'h9;
        cycle();
        iss_en = 1; iss_addr = 9; wr_data = 32'h99;
        cycle();
        idle();
        #1;
        vectors++;
        if (rd_busy !== 2'b00 || wb_err !== 1'b0) begin
            miscompares++;
            $display("FAIL same0_hold: got busy=%b err=%b want 00/0", rd_busy, wb_err);
        end
    endtask

    task automatic test_wb_err();
        set_rd(3, 0);
        wr_en = 1; wr_addr = 3; wr_data = 32'h3333_A5A5;
        #1;
        vectors++;
        if (wb_err !== 1'b0) begin
            miscompares++;
            $display("FAIL wberr_pre: got err=%b want 0", wb_err);
        end
        cycle();
        idle();
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++;
            if (wb_err !== 1'b1 || rd_data[XLEN-1:0] !== 32'h3333_A5A5) begin
                miscompares++;
                $display("FAIL wberr_sticky%0d: got err=%b data=%h want 1/3333a5a5", k, wb_err, rd_data[XLEN-1:0]);
            end
            cycle();
        end
    endtask

    task automatic test_bypass();
        set_rd(5, 0);
        wr_en = 1; wr_addr = 5; wr_data = 32'hDEAD_BEEF;
        #1;
        vectors++;
        if (rd_data[XLEN-1:0] !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL bypass_same: got %h want deadbeef", rd_data[XLEN-1:0]);
        end
        cycle();
        idle();
        set_rd(0, 5);
        #1;
        vectors++;
        if (rd_data !== {32'hDEAD_BEEF, 32'h0}) begin
            miscompares++;
            $display("FAIL bypass_array: got %h want deadbeef00000000", rd_data);
        end
        wr_en = 1; wr_addr = 0; wr_data = 32'h1234;
        set_rd(0, 0);
        #1;
        vectors++;
        if (rd_data !== '0) begin
            miscompares++;
            $display("FAIL x0_bypass: got %h want 0", rd_data);
        end
        cycle();
        idle();
        #1;
        vectors++;
        if (rd_data !== '0 || rd_busy !== '0) begin
            miscompares++;
            $display("FAIL x0_array: got data=%h busy=%b want 0/0", rd_data, rd_busy);
        end
    endtask

    task automatic test_out_of_range();
        for (int a = NREG; a < 32; a += 6) begin
            wr_en = 1; wr_addr = AW'(a); wr_data = $urandom;
            iss_en = 1; iss_addr = AW'(a);
            set_rd(a, a);
            #1;
            vectors++;
            if (rd_data !== '0 || iss_stall !== 1'b0 || rd_busy !== '0) begin
                miscompares++;
                $display("FAIL oor_comb a=%0d: got data=%h stall=%b busy=%b want 0", a, rd_data, iss_stall, rd_busy);
            end
            cycle();
            idle();
            #1;
            vectors++;
            if (rd_data !== '0 || rd_busy !== '0) begin
                miscompares++;
                $display("FAIL oor_after a=%0d: got data=%h busy=%b want 0", a, rd_data, rd_busy);
            end
        end
    endtask

    task automatic test_async_reset();
        iss_en = 1; iss_addr = 11;
        cycle();
        idle();
        set_rd(5, 11);
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (rd_data !== '0 || rd_busy !== '0 || wb_err !== 1'b0) begin
            miscompares++;
            $display("FAIL async_clear: got data=%h busy=%b err=%b want 0", rd_data, rd_busy, wb_err);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        vectors++;
        if (rd_data !== '0 || rd_busy !== '0) begin
            miscompares++;
            $display("FAIL async_state: got data=%h busy=%b want 0", rd_data, rd_busy);
        end
        wr_en = 1; wr_addr = 5; wr_data = 32'h5A5A_0005;
        cycle();
        idle();
        #1;
        vectors++;
        if (rd_data[XLEN-1:0] !== 32'h5A5A_0005) begin
            miscompares++;
            $display("FAIL first_write: got %h want 5a5a0005", rd_data[XLEN-1:0]);
        end
    endtask

    function automatic int pick_addr();
        return ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 31)) : int'($urandom_range(1, 4));
    endfunction

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            wr_en    = ($urandom_range(0, 2) == 0);
            wr_addr  = AW'(pick_addr());
            wr_data  = $urandom;
            iss_en   = ($urandom_range(0, 1) == 1);
            iss_addr = AW'(pick_addr());
            set_rd(pick_addr(), pick_addr());
            #1;
            for (int p = 0; p < NRD; p++) begin
                int a;
                a = int'(rd_addr[p*AW +: AW]);
                vectors++;
                if (rd_data[p*XLEN +: XLEN] !== exp_rd(a) || rd_busy[p] !== exp_busy(a)) begin
                    miscompares++;
                    $display("FAIL rand_rd%0d n=%0d a=%0d: got %h/%b want %h/%b", p, n, a, rd_data[p*XLEN +: XLEN], rd_busy[p], exp_rd(a), exp_busy(a));
                end
            end
            vectors++;
            if (iss_stall !== exp_stall() || wb_err !== err) begin
                miscompares++;
                $display("FAIL rand_ctl n=%0d: got stall=%b err=%b want %b/%b", n, iss_stall, wb_err, exp_stall(), err);
            end
            cycle();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_saturate();
        test_same_cycle();
        test_wb_err();
        test_bypass();
        test_out_of_range();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
